// File: rtl/host_run_pkg.sv
// ============================================================================
// Module   : host_run_pkg
// Purpose  : Shared types and default widths for the MiniMA host run
//            controller and its dump streamer.
// Contents : state_t controller states, default width localparams.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package host_run_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_I = 3'd1,
        LOAD_D = 3'd2,
        RUN    = 3'd3,
        DUMP   = 3'd4
    } state_t;

    localparam int HR_IA_W  = 12;
    localparam int HR_IW    = 9;
    localparam int HR_DA_W  = 8;
    localparam int HR_DW    = 8;
    localparam int HR_CNT_W = 32;

endpackage

`default_nettype wire

// File: rtl/host_dump_stream.sv
// ============================================================================
// Module   : host_dump_stream
// Purpose  : Streams DUMP_LEN bytes of data memory, starting at DUMP_BASE
//            (address wraps), out through a valid/ready port.  Reads are only
//            issued when the presented byte is absent or being accepted, so
//            read data appears directly on the output in the cycle after the
//            read; a one-entry hold register keeps it stable under stall.
// Ports    : clk, rst (async, high); start pulse; rd_en/rd_addr/rd_data to
//            memory (1-cycle latency); out_valid/out_ready/out_data/out_last;
//            done pulses on the final byte handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_dump_stream #(
    parameter int DA_W      = 8,
    parameter int DW        = 8,
    parameter int DUMP_BASE = 0,
    parameter int DUMP_LEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            rd_en,
    output logic [DA_W-1:0] rd_addr,
    input  logic [DW-1:0]   rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic            done
);

    localparam logic [DA_W-1:0] BASE     = DA_W'(DUMP_BASE);
    localparam logic [DA_W:0]   LEN      = (DA_W+1)'(DUMP_LEN);
    localparam logic [DA_W:0]   LAST_IDX = LEN - 1'b1;

    logic            active;
    logic [DA_W-1:0] ptr;
    logic [DA_W:0]   issued;
    logic [DA_W:0]   sent;
    logic            pending;     // read issued last cycle; rd_data valid now
    logic            hold_valid;
    logic [DW-1:0]   hold_data;
    logic            out_hs;

    assign out_valid = pending | hold_valid;
    assign out_data  = hold_valid ? hold_data : (pending ? rd_data : '0);
    assign out_last  = out_valid & (sent == LAST_IDX);
    assign out_hs    = out_valid & out_ready;
    assign done      = out_hs & out_last;
    assign rd_en     = active & (issued != LEN) & (~out_valid | out_ready);
    assign rd_addr   = ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= 1'b0;
            ptr        <= '0;
            issued     <= '0;
            sent       <= '0;
            pending    <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (start) begin
            active     <= 1'b1;
            ptr        <= BASE;
            issued     <= '0;
            sent       <= '0;
            pending    <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            if (done) begin
                active <= 1'b0;
            end
            pending <= rd_en;
            if (rd_en) begin
                ptr    <= ptr + 1'b1;
                issued <= issued + 1'b1;
            end
            if (out_hs) begin
                sent       <= sent + 1'b1;
                hold_valid <= 1'b0;
            end else if (out_valid) begin
                // Stalled: freeze the presented byte, memory output may move.
                hold_valid <= 1'b1;
                hold_data  <= out_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/host_run_ctrl.sv
// ============================================================================
// Module   : host_run_ctrl
// Purpose  : Host-side initiator for the MiniMA core: loads instruction and
//            data memory from an input stream, runs the core until Done,
//            counts run cycles, then streams a data-memory window out.
// Ports    : Clk, Reset (async, high), Start; In_* load stream; Im_* / Dm_*
//            memory back-door ports; Core_Reset/Core_Done to the core;
//            Out_* dump stream; Busy, Cycles, Timeout status.
// Options  : HOST_TIMEOUT_EN - run watchdog of MAX_CYCLES cycles; when absent
//            RUN waits indefinitely and Timeout is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_run_ctrl
    import host_run_pkg::*;
#(
    parameter int IA_W       = HR_IA_W,
    parameter int IW         = HR_IW,
    parameter int DA_W       = HR_DA_W,
    parameter int DW         = HR_DW,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_LEN   = 64,
    parameter int CNT_W      = HR_CNT_W,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [IW-1:0]    In_Data,
    input  logic             In_Last,
    output logic             Im_We,
    output logic [IA_W-1:0]  Im_Addr,
    output logic [IW-1:0]    Im_Data,
    output logic             Dm_We,
    output logic             Dm_Re,
    output logic [DA_W-1:0]  Dm_Addr,
    output logic [DW-1:0]    Dm_Wdata,
    input  logic [DW-1:0]    Dm_Rdata,
    output logic             Core_Reset,
    input  logic             Core_Done,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [DW-1:0]    Out_Data,
    output logic             Out_Last,
    output logic             Busy,
    output logic [CNT_W-1:0] Cycles,
    output logic             Timeout
);

    state_t          state, state_nxt;
    logic [IA_W-1:0] ia_cnt;
    logic [DA_W-1:0] da_cnt;
    logic            run_first;   // first RUN cycle: core PC still leaving reset
    logic            done_ok;
    logic            wd_fire;
    logic            dump_start;
    logic            dump_done;
    logic            dump_re;
    logic [DA_W-1:0] dump_addr;

    assign done_ok    = (state == RUN) & ~run_first & Core_Done;
    assign dump_start = (state == RUN) & (done_ok | wd_fire);
    assign Core_Reset = (state != RUN);
    assign Busy       = (state != IDLE);
    assign Dm_Re      = dump_re;

`ifdef HOST_TIMEOUT_EN
    assign wd_fire = (state == RUN) & ~done_ok & (Cycles == CNT_W'(MAX_CYCLES - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Timeout <= 1'b0;
        end else if (state == IDLE && Start) begin
            Timeout <= 1'b0;
        end else if (wd_fire) begin
            Timeout <= 1'b1;
        end
    end
`else
    // Watchdog compiled out; MAX_CYCLES has no effect in this build.
    assign wd_fire = 1'b0 & (MAX_CYCLES > 0);
    assign Timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        In_Ready  = 1'b0;
        Im_We     = 1'b0;
        Im_Addr   = '0;
        Im_Data   = '0;
        Dm_We     = 1'b0;
        Dm_Wdata  = '0;
        Dm_Addr   = '0;
        case (state)
            IDLE: begin
                if (Start) state_nxt = LOAD_I;
            end
            LOAD_I: begin
                In_Ready = 1'b1;
                if (In_Valid) begin
                    Im_We   = 1'b1;
                    Im_Addr = ia_cnt;
                    Im_Data = In_Data;
                    if (In_Last || ia_cnt == '1) state_nxt = LOAD_D;
                end
            end
            LOAD_D: begin
                In_Ready = 1'b1;
                if (In_Valid) begin
                    Dm_We    = 1'b1;
                    Dm_Addr  = da_cnt;
                    Dm_Wdata = In_Data[DW-1:0];
                    if (In_Last || da_cnt == '1) state_nxt = RUN;
                end
            end
            RUN: begin
                if (dump_start) state_nxt = DUMP;
            end
            DUMP: begin
                if (dump_re) Dm_Addr = dump_addr;
                if (dump_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            ia_cnt    <= '0;
            da_cnt    <= '0;
            Cycles    <= '0;
            run_first <= 1'b1;
        end else begin
            state     <= state_nxt;
            run_first <= (state != RUN);
            if (state == IDLE && Start) begin
                ia_cnt <= '0;
                da_cnt <= '0;
                Cycles <= '0;
            end
            // Counters stop at the top address; the phase exits there.
            if (Im_We && ia_cnt != '1) ia_cnt <= ia_cnt + 1'b1;
            if (Dm_We && da_cnt != '1) da_cnt <= da_cnt + 1'b1;
            if (state == RUN && Cycles != '1) Cycles <= Cycles + 1'b1;
        end
    end

    host_dump_stream #(
        .DA_W      (DA_W),
        .DW        (DW),
        .DUMP_BASE (DUMP_BASE),
        .DUMP_LEN  (DUMP_LEN)
    ) u_dump (
        .clk       (Clk),
        .rst       (Reset),
        .start     (dump_start),
        .rd_en     (dump_re),
        .rd_addr   (dump_addr),
        .rd_data   (Dm_Rdata),
        .out_valid (Out_Valid),
        .out_ready (Out_Ready),
        .out_data  (Out_Data),
        .out_last  (Out_Last),
        .done      (dump_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_host_run_ctrl.sv
// ============================================================================
// Module   : tb_host_run_ctrl
// Purpose  : Self-checking bench for host_run_ctrl (DUMP_BASE=0xFE,
//            DUMP_LEN=4, MAX_CYCLES=20).  Expected memory writes and dump
//            bytes are queued as stimulus is driven and popped by a monitor
//            when the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_host_run_ctrl;
    import host_run_pkg::*;

    localparam int IA_W  = HR_IA_W;
    localparam int IW    = HR_IW;
    localparam int DA_W  = HR_DA_W;
    localparam int DW    = HR_DW;
    localparam int CNT_W = HR_CNT_W;

    logic             Clk, Reset, Start;
    logic             In_Valid, In_Ready, In_Last;
    logic [IW-1:0]    In_Data;
    logic             Im_We;
    logic [IA_W-1:0]  Im_Addr;
    logic [IW-1:0]    Im_Data;
    logic             Dm_We, Dm_Re;
    logic [DA_W-1:0]  Dm_Addr;
    logic [DW-1:0]    Dm_Wdata, Dm_Rdata;
    logic             Core_Reset, Core_Done;
    logic             Out_Valid, Out_Ready, Out_Last;
    logic [DW-1:0]    Out_Data;
    logic             Busy, Timeout;
    logic [CNT_W-1:0] Cycles;

    host_run_ctrl #(
        .IA_W(IA_W), .IW(IW), .DA_W(DA_W), .DW(DW),
        .DUMP_BASE(254), .DUMP_LEN(4), .CNT_W(CNT_W), .MAX_CYCLES(20)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data), .In_Last(In_Last),
        .Im_We(Im_We), .Im_Addr(Im_Addr), .Im_Data(Im_Data),
        .Dm_We(Dm_We), .Dm_Re(Dm_Re), .Dm_Addr(Dm_Addr),
        .Dm_Wdata(Dm_Wdata), .Dm_Rdata(Dm_Rdata),
        .Core_Reset(Core_Reset), .Core_Done(Core_Done),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data), .Out_Last(Out_Last),
        .Busy(Busy), .Cycles(Cycles), .Timeout(Timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    logic [20:0] im_q[$];   // {addr, data}
    logic [15:0] dm_q[$];   // {addr, data}
    logic [8:0]  out_q[$];  // {last, data}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Data memory model: unwritten locations read as addr ^ 0xC3.
    logic [7:0]   mem [0:255];
    bit   [255:0] wr_ok;
    always @(posedge Clk) begin
        if (Dm_We) begin
            mem[Dm_Addr]   <= Dm_Wdata;
            wr_ok[Dm_Addr] <= 1'b1;
        end
        if (Dm_Re) Dm_Rdata <= wr_ok[Dm_Addr] ? mem[Dm_Addr] : (Dm_Addr ^ 8'hC3);
    end

    // Monitor: pops scoreboard entries when the DUT produces writes/bytes.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    always @(negedge Clk) begin
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (Im_We) begin
                tests++;
                assert (im_q.size() > 0) else begin
                    fails++;
                    $error("FAIL im_extra: observed write %0h/%0h expected none", Im_Addr, Im_Data);
                end
                if (im_q.size() > 0) chk("im_write", {Im_Addr, Im_Data}, im_q.pop_front());
            end
            if (Dm_We) begin
                tests++;
                assert (dm_q.size() > 0) else begin
                    fails++;
                    $error("FAIL dm_extra: observed write %0h/%0h expected none", Dm_Addr, Dm_Wdata);
                end
                if (dm_q.size() > 0) chk("dm_write", {Dm_Addr, Dm_Wdata}, dm_q.pop_front());
            end
            if (Out_Valid && Out_Ready) begin
                tests++;
                assert (out_q.size() > 0) else begin
                    fails++;
                    $error("FAIL out_extra: observed byte %0h expected none", Out_Data);
                end
                if (out_q.size() > 0) chk("out_byte", {Out_Last, Out_Data}, out_q.pop_front());
            end
            if (prev_stall) begin
                chk("stall_valid", Out_Valid, 1'b1);
                chk("stall_data", Out_Data, prev_data);
            end
            prev_stall = Out_Valid & ~Out_Ready;
            prev_data  = Out_Data;
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic send_i(input logic [8:0] w, input logic last, input int a);
        In_Valid = 1'b1; In_Data = w; In_Last = last;
        im_q.push_back({12'(a), w});
        tick;
        In_Valid = 1'b0; In_Last = 1'b0;
    endtask

    task automatic send_d(input logic [8:0] w, input logic last, input int a);
        In_Valid = 1'b1; In_Data = w; In_Last = last;
        dm_q.push_back({8'(a), w[7:0]});
        tick;
        In_Valid = 1'b0; In_Last = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] pat;
        Reset = 1'b1; Start = 1'b0; In_Valid = 1'b0; In_Data = '0; In_Last = 1'b0;
        Core_Done = 1'b0; Out_Ready = 1'b0;
        repeat (2) tick;
        Reset = 1'b0;
        #1;
        chk("rst_core_reset", Core_Reset, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_in_ready", In_Ready, 1'b0);
        chk("rst_out_valid", Out_Valid, 1'b0);
        chk("rst_cycles", Cycles, 0);
        chk("rst_timeout", Timeout, 1'b0);

        // Session 1: small load, Done gating, wrapped stalled dump
        Start = 1'b1; tick; Start = 1'b0;
        chk("load_i_ready", In_Ready, 1'b1);
        chk("load_i_busy", Busy, 1'b1);
        send_i(9'h1A0, 1'b0, 0);
        send_i(9'h055, 1'b0, 1);
        send_i(9'h1FF, 1'b1, 2);
        send_d(9'h112, 1'b0, 0);
        send_d(9'h034, 1'b1, 1);
        chk("run_core_reset", Core_Reset, 1'b0);
        chk("run_in_ready", In_Ready, 1'b0);
        chk("run_cycles0", Cycles, 0);
        Core_Done = 1'b1; Start = 1'b1;
        tick;
        Start = 1'b0;
        chk("done_ignored_c1", Core_Reset, 1'b0);
        Core_Done = 1'b0;
        repeat (8) tick;
        chk("run_cycles9", Cycles, 9);
        chk("run_still", Core_Reset, 1'b0);
        Core_Done = 1'b1;
        out_q.push_back({1'b0, 8'h3D});
        out_q.push_back({1'b0, 8'h3C});
        out_q.push_back({1'b0, 8'h12});
        out_q.push_back({1'b1, 8'h34});
        tick;
        Core_Done = 1'b0;
        chk("dump_core_reset", Core_Reset, 1'b1);
        chk("dump_cycles10", Cycles, 10);
        pat = 4'b1001;
        for (int i = 0; i < 60 && Busy; i++) begin
            Out_Ready = pat[i % 4];
            tick;
        end
        Out_Ready = 1'b0;
        chk("dump1_idle", Busy, 1'b0);
        chk("dump1_all_bytes", 64'(out_q.size()), 0);
        chk("idle_cycles_held", Cycles, 10);

        // Session 2: full instruction and data address range, no Last
        Start = 1'b1; tick; Start = 1'b0;
        chk("start_clears_cycles", Cycles, 0);
        for (int i = 0; i < 4096; i++) send_i(9'(i) ^ 9'h0AA, 1'b0, i);
        chk("after_4096_in_load_d", In_Ready, 1'b1);
        for (int i = 0; i < 256; i++) send_d({i[0], 8'(i) ^ 8'h5A}, 1'b0, i);
        chk("after_256_run", Core_Reset, 1'b0);
        chk("im_q_drained", 64'(im_q.size()), 0);
        out_q.push_back({1'b0, 8'hA4});
        out_q.push_back({1'b0, 8'hA5});
        out_q.push_back({1'b0, 8'h5A});
        out_q.push_back({1'b1, 8'h5B});
`ifdef HOST_TIMEOUT_EN
        repeat (19) tick;
        chk("wd_pre_cycles", Cycles, 19);
        chk("wd_pre_timeout", Timeout, 1'b0);
        chk("wd_pre_run", Core_Reset, 1'b0);
        tick;
        chk("wd_timeout", Timeout, 1'b1);
        chk("wd_cycles", Cycles, 20);
        chk("wd_dump", Core_Reset, 1'b1);
`else
        repeat (24) tick;
        chk("nowd_run", Core_Reset, 1'b0);
        chk("nowd_timeout", Timeout, 1'b0);
        chk("nowd_cycles", Cycles, 24);
        Core_Done = 1'b1;
        tick;
        Core_Done = 1'b0;
        chk("nowd_dump", Core_Reset, 1'b1);
        chk("nowd_cycles_end", Cycles, 25);
`endif
        for (int i = 0; i < 40 && Busy; i++) begin
            Out_Ready = 1'b1;
            tick;
        end
        Out_Ready = 1'b0;
        chk("dump2_idle", Busy, 1'b0);
        chk("dump2_all_bytes", 64'(out_q.size()), 0);
`ifdef HOST_TIMEOUT_EN
        chk("timeout_sticky", Timeout, 1'b1);
`endif

        // Session 3: reset during DUMP
        Start = 1'b1; tick; Start = 1'b0;
        chk("s3_timeout_clear", Timeout, 1'b0);
        send_i(9'h001, 1'b1, 0);
        send_d(9'h077, 1'b1, 0);
        Core_Done = 1'b1;
        repeat (2) tick;
        Core_Done = 1'b0;
        chk("s3_dump_re", Dm_Re, 1'b1);
        chk("s3_dump_addr", Dm_Addr, 8'hFE);
        tick;
        chk("s3_out_valid", Out_Valid, 1'b1);
        chk("s3_out_data", Out_Data, 8'hA4);
        tick;
        Reset = 1'b1;
        #1;
        chk("abort_out_valid", Out_Valid, 1'b0);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_core_reset", Core_Reset, 1'b1);
        chk("abort_dm_re", Dm_Re, 1'b0);
        tick;
        Reset = 1'b0;
        tick;
        chk("post_abort_idle", Busy, 1'b0);
        chk("post_abort_in_ready", In_Ready, 1'b0);
        chk("dm_q_drained", 64'(dm_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
